// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target byte controller: oversampled START/STOP detection, 7-bit
// address match, write-byte receive with host ACK and read-byte transmit.
`timescale 1ns/1ps
module i2c_slave_byte_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic [6:0] slave_addr,
  input  logic       ack_in,
  input  logic [7:0] tx_data,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oen,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  output logic       master_nack,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output logic       rw
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK
  } state_t;

  logic scl_m_q, scl_s_q, scl_h_q;
  logic sda_m_q, sda_s_q, sda_h_q;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       ack_q, ack_d;
  logic       pend_q, pend_d;
  logic       oen_q, oen_d;
  logic [7:0] rxd_q, rxd_d;
  logic       rxv_q, rxv_d;
  logic       rxf_q, rxf_d;
  logic       txr_q, txr_d;
  logic       mnack_q, mnack_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  logic       scl_rise, scl_fall, scl_hi;
  logic       start_c, stop_c;
  logic [7:0] shifted;

  // Idle bus is high; synchronizers reset high to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_h_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_h_q <= 1'b1;
    end else begin
      scl_m_q <= scl_i;
      scl_s_q <= scl_m_q;
      scl_h_q <= scl_s_q;
      sda_m_q <= sda_i;
      sda_s_q <= sda_m_q;
      sda_h_q <= sda_s_q;
    end
  end

  assign scl_rise = scl_s_q & ~scl_h_q;
  assign scl_fall = ~scl_s_q & scl_h_q;
  assign scl_hi   = scl_s_q & scl_h_q;
  assign start_c  = scl_hi & ~sda_s_q & sda_h_q;
  assign stop_c   = scl_hi & sda_s_q & ~sda_h_q;
  assign shifted  = {sr_q[6:0], sda_s_q};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= 8'h00;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      oen_q   <= 1'b1;
      rxd_q   <= 8'h00;
      rxv_q   <= 1'b0;
      rxf_q   <= 1'b0;
      txr_q   <= 1'b0;
      mnack_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      oen_q   <= oen_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      rxf_q   <= rxf_d;
      txr_q   <= txr_d;
      mnack_q <= mnack_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ack_d   = ack_q;
    pend_d  = pend_q;
    oen_d   = oen_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    rxf_d   = 1'b0;
    txr_d   = 1'b0;
    mnack_d = 1'b0;
    start_d = 1'b0;
    stop_d  = 1'b0;
    busy_d  = busy_q;
    rw_d    = rw_q;

    if (!ena) begin
      state_d = IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
    end else if (start_c) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
      start_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shifted[7:1] == slave_addr) begin
                state_d = ADDR_ACK;
                ack_d   = 1'b0;
                rw_d    = shifted[0];
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        // ack_q marks the second half of an ACK slot (driven, awaiting release)
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              ack_d  = 1'b1;
              oen_d  = 1'b0;
              busy_d = 1'b1;
            end else if (!rw_q) begin
              oen_d   = 1'b1;
              state_d = RX;
              pend_d  = 1'b1;
              cnt_d   = 3'd0;
            end else begin
              state_d = TX;
              txr_d   = 1'b1;
              sr_d    = tx_data;
              oen_d   = tx_data[7];
              cnt_d   = 3'd0;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rxd_d   = shifted;
              rxv_d   = 1'b1;
              rxf_d   = pend_q;
              pend_d  = 1'b0;
              state_d = RX_ACK;
              ack_d   = 1'b0;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              ack_d = 1'b1;
              oen_d = ack_in;
            end else begin
              oen_d   = 1'b1;
              state_d = RX;
              cnt_d   = 3'd0;
            end
          end
        end
        TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              oen_d   = 1'b1;
              state_d = TX_ACK;
              ack_d   = 1'b0;
            end else begin
              sr_d  = {sr_q[6:0], sr_q[7]};
              oen_d = sr_q[6];
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s_q) begin
              mnack_d = 1'b1;
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ack_d = 1'b1;
            end
          end else if (scl_fall && ack_q) begin
            state_d = TX;
            txr_d   = 1'b1;
            sr_d    = tx_data;
            oen_d   = tx_data[7];
            cnt_d   = 3'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oen     = oen_q;
  assign rx_data     = rxd_q;
  assign rx_valid    = rxv_q;
  assign rx_first    = rxf_q;
  assign tx_req      = txr_q;
  assign master_nack = mnack_q;
  assign start_det   = start_q;
  assign stop_det    = stop_q;
  assign busy        = busy_q;
  assign rw          = rw_q;

endmodule
